regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Write-side controller for the CPU's integer register file: merges single-cycle ALU results and multi-cycle load/store-unit (LSU) results onto the register file's single synchronous write port. It also keeps a scoreboard of destination registers with outstanding LSU results, so ID can stall on reads. It sits in the writeback stage, directly driving the register file's write data, address and enable.

## Interface
- `AWIDTH`, 5, register address width
- `DWIDTH`, 32, register data width
- `NREGS`, 32, number of architectural registers (scoreboard bits)
- `FIFO_DEPTH`, 2, LSU result buffer entries (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle; always accepted
- `alu_rd`  in  AWIDTH  ALU destination register
- `alu_data`  in  DWIDTH  ALU result
- `lsu_valid`  in  1  LSU result offered
- `lsu_ready`  out  1  LSU result accepted when `lsu_valid && lsu_ready`
- `lsu_rd`  in  AWIDTH  LSU destination register
- `lsu_data`  in  DWIDTH  LSU result
- `issue_valid`  in  1  long-latency op issued; mark `issue_rd` busy
- `issue_rd`  in  AWIDTH  destination of issued op
- `rs1_addr`, `rs2_addr`  in  AWIDTH  ID read addresses
- `rs1_busy`, `rs2_busy`  out  1  scoreboard bit for each read address (combinational)
- `wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  AWIDTH  register-file write address (registered)
- `wr_data`  out  DWIDTH  register-file write data (registered)

## Operation
- LSU results are enqueued into a FIFO_DEPTH-entry FIFO of {rd, data}; `lsu_ready = !fifo_full`, combinational from state only (no dependence on `lsu_valid`).
- Arbiter per cycle: `alu_valid` wins; else FIFO head if non-empty (dequeued); else idle.
- Selected result registered onto `wr_*`; `wr_en` = selection made AND rd ≠ 0. Writes to x0 are consumed (FIFO still pops) but never assert `wr_en`.
- Scoreboard: NREGS-bit vector; bit 0 hard-wired 0.
  - set on `issue_valid` for `issue_rd` ≠ 0.
  - cleared for `wr_addr` on the edge where `wr_en` is high and the registered write came from the FIFO.
  - set and clear of the same bit on the same edge: set wins.
  - ALU writes never touch the scoreboard.
- `rsN_busy = scoreboard[rsN_addr]`.
- Reset: FIFO empty, scoreboard all 0, `wr_en`=0, `wr_addr`=0, `wr_data`=0; hence `lsu_ready`=1, `rs1_busy`=`rs2_busy`=0.

## Timing
- ALU result at cycle N → `wr_en` high in cycle N+1, regfile commits at end of N+1.
- LSU accepted at edge ending N → head visible N+1 → if no `alu_valid` in N+1, `wr_en` high in N+2. Each ALU-valid cycle delays the head by one cycle.
- Scoreboard bit drops in the cycle after the LSU `wr_en` cycle, so a read in that cycle sees committed data.
- Full FIFO: `lsu_ready`=0 even if a pop occurs the same cycle (no pass-through); `lsu_ready` returns the cycle after the pop.
- Enqueue and dequeue in the same cycle when not full: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- Continuous `alu_valid` starves the FIFO by design; LSU back-pressures via `lsu_ready`.
- `rst_n` asserted mid-operation: all state clears immediately, asynchronously. Pending FIFO entries are lost. The upstream pipeline is reset by the same signal.

## Structure
- Shared constants header `riscv_wb_defs`: source-select encodings (NONE/ALU/LSU), default widths, `X0` address constant.
- One sub-module, `wb_fifo`: parameterised sync FIFO with async active-low reset, `full`/`empty` flags, and occupancy counter of width log2(FIFO_DEPTH)+1.
- Top level holds the arbiter, the output registers, the source-tag register and the scoreboard.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `wr_en`=0, `wr_addr`=0, `wr_data`=0, `lsu_ready`=1, both busy outputs 0.
- ALU only: `alu_valid`, rd=5, data=0xDEADBEEF at cycle N → `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF in N+1; rd=0 → `wr_en` stays 0.
- LSU vs ALU contention: issue rd=7; LSU rd=7, data=0x1234 at N; `alu_valid` in N+1 and N+2 → LSU write appears at N+4. `rs1_addr`=7 shows busy through N+4 and clear at N+5.
- FIFO full: three back-to-back LSU offers under constant `alu_valid` → `lsu_ready`=0 after two accepts. Drop `alu_valid` → writes drain in order and `lsu_ready` returns 1 the cycle after the first pop.
- Set/clear collision: LSU write to rd=9 commits on the same edge as `issue_valid` rd=9 → bit 9 remains set.
- Async reset mid-drain: assert `rst_n`=0 with 2 FIFO entries and busy bits set → outputs clear without a clock edge. No writes issue after release.

Source files
------------

// File: rtl/riscv_wb_defs.sv
// Shared writeback-stage constants: default widths, source-select tags and the x0 address.
// Imported by the writeback controller and its FIFO.
package riscv_wb_defs;

  localparam int unsigned AWIDTH_DEF     = 5;
  localparam int unsigned DWIDTH_DEF     = 32;
  localparam int unsigned NREGS_DEF      = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 2;

  // Architectural zero register; writes to it are dropped.
  localparam int unsigned X0 = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO, head visible the cycle after push.
// Pushes while full and pops while empty are ignored; no full-cycle pass-through.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter (ALU over buffered LSU) with a pending-load scoreboard.
// Writes are registered one cycle after selection; LSU is back-pressured only by a full buffer.
module regfile_wb_ctrl
  import riscv_wb_defs::*;
#(
  parameter int unsigned AWIDTH     = AWIDTH_DEF,
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned NREGS      = NREGS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [AWIDTH-1:0] alu_rd,
  input  logic [DWIDTH-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AWIDTH-1:0] lsu_rd,
  input  logic [DWIDTH-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic [AWIDTH-1:0] issue_rd,
  input  logic [AWIDTH-1:0] rs1_addr,
  input  logic [AWIDTH-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data
);

  localparam int unsigned EW = AWIDTH + DWIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  wb_src_e           sel_src;
  logic [AWIDTH-1:0] sel_rd;
  logic [DWIDTH-1:0] sel_data;
  wb_src_e           wr_src;

  logic [NREGS-1:0]  sb_q;
  logic [NREGS-1:0]  sb_d;
  logic              sb_clr_vld;

  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && !fifo_full;
  assign fifo_pop  = (sel_src == SRC_LSU);

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({lsu_rd, lsu_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ALU is never stalled, so it always wins; the buffered LSU head waits.
  always_comb begin
    sel_src  = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid) begin
      sel_src  = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (!fifo_empty) begin
      sel_src  = SRC_LSU;
      sel_rd   = fifo_head[EW-1:DWIDTH];
      sel_data = fifo_head[DWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= SRC_NONE;
    end else begin
      wr_en  <= (sel_src != SRC_NONE) && (sel_rd != AWIDTH'(X0));
      wr_src <= sel_src;
      if (sel_src != SRC_NONE) begin
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  // Clear only for LSU commits; a same-edge reissue of that register keeps it busy.
  assign sb_clr_vld = wr_en && (wr_src == SRC_LSU);

  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (sb_clr_vld && (wr_addr == AWIDTH'(i))) sb_d[i] = 1'b0;
      if (issue_valid && (issue_rd == AWIDTH'(i))) sb_d[i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (rs1_addr == AWIDTH'(i)) rs1_busy = sb_q[i];
      if (rs2_addr == AWIDTH'(i)) rs2_busy = sb_q[i];
    end
  end

  a_fifo_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CW'(FIFO_DEPTH));

endmodule
